// File: rtl/ntt_coeff_stream_adapter.sv
// ntt_coeff_stream_adapter
// Serial-to-parallel front end and parallel-to-serial back end around the NTT/INTT PU.
// D coefficients are gathered from the slave stream into pu_a. The adapter then waits a
// fixed PU latency and captures pu_an. The captured vector is replayed on the master
// stream. Only one transform is in flight at a time.
module ntt_coeff_stream_adapter #(
    parameter int N       = 17,
    parameter int D       = 16,
    parameter int LATENCY = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [N-1:0]   s_data,
    input  logic           s_inv,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [N-1:0]   m_data,
    output logic           m_last,
    output logic [D*N-1:0] pu_a,
    output logic           pu_inv,
    input  logic [D*N-1:0] pu_an,
    output logic           busy
);

    // Counter widths never go below one bit, so that D or LATENCY can be 1.
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
    localparam logic [WW-1:0] W_LAST   = WW'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   in_cnt;
    logic [CW-1:0]   out_cnt;
    logic [WW-1:0]   w_cnt;
    logic [D*N-1:0]  obuf;
    logic            s_fire;
    logic            m_fire;

    assign s_fire = s_valid && s_ready;
    assign m_fire = m_valid && m_ready;

    // Next-state and handshake outputs. Everything is held inactive while rst is low.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        m_data    = '0;
        busy      = 1'b0;
        if (rst) begin
            case (state)
                S_LOAD: begin
                    s_ready = 1'b1;
                    if (s_valid && (in_cnt == CNT_LAST)) state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    busy = 1'b1;
                    if (w_cnt == W_LAST) state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    busy    = 1'b1;
                    m_valid = 1'b1;
                    m_data  = obuf[int'(out_cnt)*N +: N];
                    m_last  = (out_cnt == CNT_LAST);
                    if (m_ready && (out_cnt == CNT_LAST)) state_nxt = S_LOAD;
                end
                default: state_nxt = S_LOAD;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_LOAD;
        else      state <= state_nxt;
    end

    // Load path: each accepted coefficient is written into its pu_a slot. The direction comes from coefficient 0 only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            in_cnt <= '0;
            pu_a   <= '0;
            pu_inv <= 1'b0;
        end else if (s_fire) begin
            pu_a[int'(in_cnt)*N +: N] <= s_data;
            if (in_cnt == '0) pu_inv <= s_inv;
            if (in_cnt == CNT_LAST) in_cnt <= '0;
            else                    in_cnt <= in_cnt + CW'(1);
        end
    end

    // Latency wait: count from the vector-complete edge and capture pu_an on the last count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_cnt <= '0;
            obuf  <= '0;
        end else if (s_fire && (in_cnt == CNT_LAST)) begin
            w_cnt <= '0;
        end else if (state == S_WAIT) begin
            w_cnt <= w_cnt + WW'(1);
            if (w_cnt == W_LAST) obuf <= pu_an;
        end
    end

    // Drain path: advance the output slot on each accepted coefficient and wrap after m_last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_cnt <= '0;
        end else if (m_fire) begin
            if (out_cnt == CNT_LAST) out_cnt <= '0;
            else                     out_cnt <= out_cnt + CW'(1);
        end
    end

endmodule
